// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one i2c_master write port between N_REQ command sources.
// Optional retry of errored commands is built when I2C_ARB_RETRY_EN is defined.
module i2c_cmd_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                 i2c_clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [24*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_err,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic [23:0]          m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 m_error
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT_LOW, WAIT_HIGH, DONE} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gidx;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [IW:0]   idx_sum;
    logic          retry_ok;

    if (N_REQ < 2 || N_REQ > 8 || MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_cfg
        $error("i2c_cmd_arbiter: N_REQ must be 2..8 and MAX_RETRY 0..15");
    end

`ifdef I2C_ARB_RETRY_EN
    logic [3:0] retry_cnt;
    assign retry_ok = retry_cnt < 4'(MAX_RETRY);
`else
    assign retry_ok = 1'b0;
`endif

    assign busy = state != IDLE;

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx_sum    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            idx_sum = idx_sum >= (IW+1)'(N_REQ) ? idx_sum - (IW+1)'(N_REQ) : idx_sum;
            if (req_valid[idx_sum[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx_sum[IW-1:0];
            end
        end
    end

    // Transaction FSM with registered master handshake, grant and completion pulses
    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gidx     <= '0;
            grant    <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
`ifdef I2C_ARB_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: state <= |req_valid ? ARB : IDLE;
                ARB: begin
                    if (pick_found) begin
                        grant   <= N_REQ'(1) << pick_idx;
                        gidx    <= pick_idx;
                        m_data  <= req_data[int'(pick_idx)*24 +: 24];
                        m_valid <= 1'b1;
                        state   <= ISSUE;
`ifdef I2C_ARB_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= WAIT_LOW;
                    end
                end
                WAIT_LOW: state <= m_ready ? WAIT_LOW : WAIT_HIGH;
                WAIT_HIGH: begin
                    if (m_ready) begin
                        if (m_error && retry_ok) begin
                            m_valid <= 1'b1;
                            state   <= ISSUE;
`ifdef I2C_ARB_RETRY_EN
                            retry_cnt <= retry_cnt + 1'b1;
`endif
                        end else begin
                            req_done <= grant;
                            req_err  <= m_error ? grant : '0;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= gidx == IW'(N_REQ - 1) ? '0 : gidx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed bench for i2c_cmd_arbiter with a behavioural i2c_master model
module tb_i2c_cmd_arbiter;
    logic        i2c_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [23:0] d0 = '0;
    logic [23:0] d1 = '0;
    logic [47:0] req_data;
    logic [1:0]  req_done, req_err, grant;
    logic        busy;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_error = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          lat = 3;
    logic [31:0] err_mask = '0;
    int          accept_cnt = 0;
    logic [23:0] first_data = '0;
    logic        data_diff = 1'b0;

`ifdef I2C_ARB_RETRY_EN
    localparam int         EXP_RETRY_ACC = 3;
    localparam logic [1:0] EXP_RETRY_ERR = 2'b00;
    localparam int         EXP_EXH_ACC   = 4;
`else
    localparam int         EXP_RETRY_ACC = 1;
    localparam logic [1:0] EXP_RETRY_ERR = 2'b01;
    localparam int         EXP_EXH_ACC   = 1;
`endif

    assign req_data = {d1, d0};

    always #5 i2c_clk = ~i2c_clk;

    i2c_cmd_arbiter #(.N_REQ(2), .MAX_RETRY(3)) dut (
        .i2c_clk  (i2c_clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_done (req_done),
        .req_err  (req_err),
        .grant    (grant),
        .busy     (busy),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_error  (m_error)
    );

    // Master model: accepts on m_valid && m_ready, stays busy lat cycles, reports err_mask[attempt]
    initial begin
        int att;
        forever begin
            @(negedge i2c_clk);
            if (m_valid && m_ready) begin
                if (accept_cnt == 0) first_data = m_data;
                else if (m_data !== first_data) data_diff = 1'b1;
                @(posedge i2c_clk);
                #1;
                att = accept_cnt;
                accept_cnt++;
                m_error = 1'b0;
                m_ready = 1'b0;
                repeat (lat) @(posedge i2c_clk);
                #1;
                m_error = err_mask[att[4:0]];
                m_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge i2c_clk);
    endtask

    task automatic reset_dut;
        req_valid = '0;
        for (int i = 0; i < 200 && !m_ready; i++) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        accept_cnt = 0;
        data_diff  = 1'b0;
        err_mask   = '0;
    endtask

    task automatic wait_done(input int bound, output logic ok, output logic [1:0] dv,
                             output logic [1:0] ev, output int gap, output int gbad);
        int   rise_at;
        logic prev;
        ok = 1'b0; dv = '0; ev = '0; gap = -1; gbad = 0; rise_at = -100; prev = m_ready;
        for (int i = 0; i < bound; i++) begin
            tick;
            if ($countones(grant) > 1) gbad++;
            if (m_ready && !prev) rise_at = i;
            prev = m_ready;
            if (req_done != '0) begin
                ok = 1'b1; dv = req_done; ev = req_err; gap = i - rise_at;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== 24'h0) begin errors++; $display("FAIL rst_m_data got %h exp 000000", m_data); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if ({req_done, req_err} !== 4'b0) begin errors++; $display("FAIL rst_done_err got %b exp 0000", {req_done, req_err}); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        logic ok; logic [1:0] dv, ev; int gap, gbad;
        lat = 50; err_mask = '0; accept_cnt = 0;
        d0 = 24'h341EFF; req_valid = 2'b01;
        tick;
        checks++; if ({busy, m_valid} !== 2'b10) begin errors++; $display("FAIL single_arb busy,m_valid got %b exp 10", {busy, m_valid}); end
        tick;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_latency m_valid got %b exp 1", m_valid); end
        checks++; if (m_data !== 24'h341EFF) begin errors++; $display("FAIL single_m_data got %h exp 341eff", m_data); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", grant); end
        wait_done(200, ok, dv, ev, gap, gbad);
        req_valid = '0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got %b exp 1", ok); end
        checks++; if ({dv, ev} !== 4'b0100) begin errors++; $display("FAIL single_done_err got %b exp 0100", {dv, ev}); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL single_done_gap got %0d exp 1", gap); end
        tick;
        checks++; if ({req_done, grant, busy} !== 5'b0) begin errors++; $display("FAIL single_after got %b exp 00000", {req_done, grant, busy}); end
        checks++; if (accept_cnt !== 1) begin errors++; $display("FAIL single_accepts got %0d exp 1", accept_cnt); end
    endtask

    task automatic test_contention;
        logic ok; logic [1:0] dv, ev, exp_g; int gap, gbad, n, gbad_tot;
        reset_dut;
        lat = 3; gbad_tot = 0;
        d0 = 24'hA00000; d1 = 24'hB00000; req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            for (int i = 0; i < 10 && !m_valid; i++) begin tick; n++; end
            exp_g = t % 2 == 0 ? 2'b01 : 2'b10;
            checks++; if (n !== (t == 0 ? 2 : 3)) begin errors++; $display("FAIL cont_latency%0d got %0d exp %0d", t, n, t == 0 ? 2 : 3); end
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", t, grant, exp_g); end
            checks++; if (m_data !== (exp_g[0] ? d0 : d1)) begin errors++; $display("FAIL cont_m_data%0d got %h exp %h", t, m_data, exp_g[0] ? d0 : d1); end
            wait_done(100, ok, dv, ev, gap, gbad);
            gbad_tot += gbad;
            checks++; if ({ok, dv, ev} !== {1'b1, exp_g, 2'b00}) begin errors++; $display("FAIL cont_done%0d got %b exp %b", t, {ok, dv, ev}, {1'b1, exp_g, 2'b00}); end
            if (exp_g[0]) d0 = d0 + 24'h1; else d1 = d1 + 24'h1;
        end
        req_valid = '0;
        checks++; if (gbad_tot !== 0) begin errors++; $display("FAIL cont_onehot got %0d exp 0", gbad_tot); end
        tick;
    endtask

    task automatic test_retry;
        logic ok; logic [1:0] dv, ev; int gap, gbad;
        reset_dut;
        lat = 5; err_mask = 32'h3;
        d0 = 24'h5A0A11; req_valid = 2'b01;
        wait_done(400, ok, dv, ev, gap, gbad);
        req_valid = '0;
        checks++; if ({ok, dv} !== 3'b101) begin errors++; $display("FAIL retry_done got %b exp 101", {ok, dv}); end
        checks++; if (ev !== EXP_RETRY_ERR) begin errors++; $display("FAIL retry_err got %b exp %b", ev, EXP_RETRY_ERR); end
        checks++; if (accept_cnt !== EXP_RETRY_ACC) begin errors++; $display("FAIL retry_accepts got %0d exp %0d", accept_cnt, EXP_RETRY_ACC); end
        checks++; if ({data_diff, first_data} !== {1'b0, 24'h5A0A11}) begin errors++; $display("FAIL retry_data got %b/%h exp 0/5a0a11", data_diff, first_data); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL retry_gap got %0d exp 1", gap); end
        tick;
    endtask

    task automatic test_retry_exhausted;
        logic ok; logic [1:0] dv, ev; int gap, gbad;
        reset_dut;
        lat = 4; err_mask = 32'hFFFF_FFFF;
        d0 = 24'h1234C3; req_valid = 2'b01;
        wait_done(400, ok, dv, ev, gap, gbad);
        req_valid = '0;
        checks++; if ({ok, dv, ev} !== 5'b10101) begin errors++; $display("FAIL exh_done_err got %b exp 10101", {ok, dv, ev}); end
        checks++; if (accept_cnt !== EXP_EXH_ACC) begin errors++; $display("FAIL exh_accepts got %0d exp %0d", accept_cnt, EXP_EXH_ACC); end
        checks++; if (data_diff !== 1'b0) begin errors++; $display("FAIL exh_data_stable got %b exp 0", data_diff); end
        tick;
    endtask

    task automatic test_withdraw;
        logic ok; logic [1:0] dv, ev; int gap, gbad, acc0;
        reset_dut;
        lat = 6;
        d1 = 24'h7E2233; req_valid = 2'b10;
        for (int i = 0; i < 10 && !m_valid; i++) tick;
        checks++; if ({grant, m_data} !== {2'b10, 24'h7E2233}) begin errors++; $display("FAIL wd_grant got %b/%h exp 10/7e2233", grant, m_data); end
        tick; tick;
        req_valid = '0;
        wait_done(100, ok, dv, ev, gap, gbad);
        checks++; if ({ok, dv, ev} !== 5'b11000) begin errors++; $display("FAIL wd_done got %b exp 11000", {ok, dv, ev}); end
        tick;
        acc0 = accept_cnt;
        req_valid = 2'b01;
        tick;
        req_valid = '0;
        tick;
        checks++; if ({m_valid, grant, busy} !== 4'b0) begin errors++; $display("FAIL pulse_arb_idle got %b exp 0000", {m_valid, grant, busy}); end
        tick; tick; tick;
        checks++; if (accept_cnt !== acc0 || m_valid !== 1'b0) begin errors++; $display("FAIL pulse_no_issue got %0d/%b exp %0d/0", accept_cnt, m_valid, acc0); end
    endtask

    task automatic test_reset_mid;
        logic ok; logic [1:0] dv, ev; int gap, gbad, early;
        reset_dut;
        lat = 20;
        d0 = 24'h44AA55; req_valid = 2'b01;
        for (int i = 0; i < 10 && !m_valid; i++) tick;
        tick;
        checks++; if ({busy, m_valid} !== 2'b10) begin errors++; $display("FAIL rm_wait_low got %b exp 10", {busy, m_valid}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({m_valid, grant, busy, req_done, req_err} !== 8'b0 || m_data !== 24'h0) begin errors++; $display("FAIL rm_async got %b/%h exp 0/000000", {m_valid, grant, busy, req_done, req_err}, m_data); end
        tick; tick; tick;
        rst_n = 1'b1;
        early = 0;
        for (int i = 0; i < 100 && !m_ready; i++) begin
            tick;
            if (accept_cnt != 1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL rm_early_accept got %0d exp 0", early); end
        checks++; if ({m_ready, m_valid} !== 2'b11) begin errors++; $display("FAIL rm_issue_wait got %b exp 11", {m_ready, m_valid}); end
        wait_done(100, ok, dv, ev, gap, gbad);
        req_valid = '0;
        checks++; if ({ok, dv, ev} !== 5'b10100) begin errors++; $display("FAIL rm_done got %b exp 10100", {ok, dv, ev}); end
        checks++; if (accept_cnt !== 2) begin errors++; $display("FAIL rm_accepts got %0d exp 2", accept_cnt); end
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_retry;
        test_retry_exhausted;
        test_withdraw;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
